// File: rtl/camera_config_sequencer.sv
// camera_config_sequencer: walks a ROM table of {register, value} entries and feeds
// them to the SCCB write engine, honouring inline millisecond delays and an end marker.
module camera_config_sequencer #(
    parameter int CLK_FREQ   = 25000000,
    parameter int ADDR_W     = 8,
    parameter int POWERUP_MS = 1,
    parameter bit AUTO_START = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_start,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [15:0]       rom_data,
    input  logic              sccb_ready,
    output logic              sccb_start,
    output logic [7:0]        sccb_address,
    output logic [7:0]        sccb_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   write_count
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_POWERUP   = 4'd1;
    localparam logic [3:0] ST_FETCH     = 4'd2;
    localparam logic [3:0] ST_DECODE    = 4'd3;
    localparam logic [3:0] ST_WAIT_IDLE = 4'd4;
    localparam logic [3:0] ST_ISSUE     = 4'd5;
    localparam logic [3:0] ST_WAIT_DONE = 4'd6;
    localparam logic [3:0] ST_DELAY     = 4'd7;
    localparam logic [3:0] ST_NEXT      = 4'd8;
    localparam logic [3:0] ST_DONE      = 4'd9;

    localparam logic [31:0]       MS_CYCLES      = 32'(CLK_FREQ / 1000);
    localparam logic [31:0]       POWERUP_CYCLES = 32'(POWERUP_MS) * MS_CYCLES;
    localparam logic [ADDR_W-1:0] ADDR_LAST      = '1;
    localparam logic [7:0]        CTRL_REG       = 8'hFF;
    localparam logic [7:0]        END_VAL        = 8'hFF;

    function automatic logic [31:0] ms_to_cycles(input logic [7:0] ms);
        return 32'(ms) * MS_CYCLES;
    endfunction

    logic [3:0]  state_r;
    logic [3:0]  state_nxt_s;
    logic [31:0] delay_cnt_r;
    logic        auto_pending_r;
    logic        start_req_s;
    logic        run_start_s;
    logic        is_ctrl_s;
    logic        is_end_s;
    logic        delay_zero_s;
    logic        delay_expired_s;
    logic        last_entry_s;
    logic        enter_done_s;

    // Decode of the current ROM word, counter expiry and run-start request.
    always_comb begin
        start_req_s     = cfg_start | auto_pending_r;
        is_ctrl_s       = (rom_data[15:8] == CTRL_REG);
        is_end_s        = is_ctrl_s && (rom_data[7:0] == END_VAL);
        delay_zero_s    = (rom_data[7:0] == 8'h00);
        delay_expired_s = (delay_cnt_r <= 32'd1);
        last_entry_s    = (rom_addr == ADDR_LAST);
        if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
            run_start_s = start_req_s;
        end else begin
            run_start_s = 1'b0;
        end
    end

    // Next-state selection for the table walk.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE, ST_DONE: begin
                if (start_req_s) state_nxt_s = ST_POWERUP;
                else             state_nxt_s = state_r;
            end
            ST_POWERUP: begin
                if (delay_expired_s) state_nxt_s = ST_FETCH;
                else                 state_nxt_s = ST_POWERUP;
            end
            ST_FETCH: state_nxt_s = ST_DECODE;
            ST_DECODE: begin
                if (is_end_s)          state_nxt_s = ST_DONE;
                else if (!is_ctrl_s)   state_nxt_s = ST_WAIT_IDLE;
                else if (delay_zero_s) state_nxt_s = ST_NEXT;
                else                   state_nxt_s = ST_DELAY;
            end
            // Waiting for ready here also absorbs a write left in flight by a reset.
            ST_WAIT_IDLE: begin
                if (sccb_ready) state_nxt_s = ST_ISSUE;
                else            state_nxt_s = ST_WAIT_IDLE;
            end
            ST_ISSUE: begin
                if (!sccb_ready) state_nxt_s = ST_WAIT_DONE;
                else             state_nxt_s = ST_ISSUE;
            end
            ST_WAIT_DONE: begin
                if (sccb_ready) state_nxt_s = ST_NEXT;
                else            state_nxt_s = ST_WAIT_DONE;
            end
            ST_DELAY: begin
                if (delay_expired_s) state_nxt_s = ST_NEXT;
                else                 state_nxt_s = ST_DELAY;
            end
            ST_NEXT: begin
                if (last_entry_s) state_nxt_s = ST_DONE;
                else              state_nxt_s = ST_FETCH;
            end
            default: state_nxt_s = ST_IDLE;
        endcase
        enter_done_s = (state_nxt_s == ST_DONE) && (state_r != ST_DONE);
    end

    // State, delay counter and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= ST_IDLE;
            delay_cnt_r    <= 32'd0;
            auto_pending_r <= AUTO_START;
            rom_addr       <= '0;
            sccb_start     <= 1'b0;
            sccb_address   <= 8'h00;
            sccb_data      <= 8'h00;
            busy           <= 1'b0;
            done           <= 1'b0;
            write_count    <= '0;
        end else begin
            state_r <= state_nxt_s;
            if (run_start_s) begin
                auto_pending_r <= 1'b0;
            end
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    sccb_start <= 1'b0;
                    if (start_req_s) begin
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        write_count <= '0;
                        rom_addr    <= '0;
                        delay_cnt_r <= POWERUP_CYCLES;
                    end
                end
                ST_POWERUP, ST_DELAY: begin
                    if (!delay_expired_s) delay_cnt_r <= delay_cnt_r - 32'd1;
                end
                ST_DECODE: begin
                    if (!is_ctrl_s) begin
                        sccb_address <= rom_data[15:8];
                        sccb_data    <= rom_data[7:0];
                    end else if (!is_end_s && !delay_zero_s) begin
                        delay_cnt_r <= ms_to_cycles(rom_data[7:0]);
                    end
                end
                ST_WAIT_IDLE: begin
                    if (sccb_ready) sccb_start <= 1'b1;
                end
                ST_ISSUE: begin
                    if (!sccb_ready) begin
                        sccb_start  <= 1'b0;
                        write_count <= write_count + (ADDR_W+1)'(1);
                    end
                end
                ST_NEXT: begin
                    if (!last_entry_s) rom_addr <= rom_addr + ADDR_W'(1);
                end
                ST_FETCH, ST_WAIT_DONE: begin
                end
                default: begin
                    busy       <= 1'b0;
                    sccb_start <= 1'b0;
                end
            endcase
            if (enter_done_s) begin
                busy       <= 1'b0;
                done       <= 1'b1;
                sccb_start <= 1'b0;
            end
        end
    end

endmodule
